// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: stage occupancy states and the packed
// bundles carried between processor stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [5:0]  ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [31:0] alu_res;
    logic [4:0]  rd;
    logic [1:0]  ctrl;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel between two pipeline stages.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 107
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional skid entry (registered in_ready) and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W        = EX_MEM_W,
  parameter int SKID          = 1,
  parameter int ZERO_ON_FLUSH = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              in_rdy;
  logic              out_vld;
  logic [DATA_W-1:0] out_dat;
  logic              xfer_in;
  logic              xfer_out;

  assign xfer_in  = up.valid && in_rdy;
  assign xfer_out = out_vld && dn.ready;

  assign up.ready = in_rdy;
  assign dn.valid = out_vld;
  assign dn.data  = out_dat;

  generate
    if (SKID != 0) begin : g_skid
      stage_state_e      state_q, state_d;
      logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
      logic              vld_q, rdy_q;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
          EMPTY: if (xfer_in) begin
                   state_d = ONE;
                   main_d  = up.data;
                 end
          ONE: begin
            if (xfer_in && xfer_out) begin
              main_d = up.data;
            end else if (xfer_in) begin
              state_d = FULL;
              skid_d  = up.data;
            end else if (xfer_out) begin
              state_d = EMPTY;
            end
          end
          FULL: if (xfer_out) begin
                  state_d = ONE;
                  main_d  = skid_q;
                end
          default: state_d = EMPTY;
        endcase
        // Flush overrides any transfer decided above.
        if (flush) begin
          state_d = EMPTY;
          if (ZERO_ON_FLUSH != 0) begin
            main_d = '0;
            skid_d = '0;
          end
        end
      end

      // Handshake outputs are re-registered from the next state so both are flops.
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          vld_q   <= (state_d != EMPTY);
          rdy_q   <= (state_d != FULL);
        end

      assign in_rdy  = rdy_q;
      assign out_vld = vld_q;
      assign out_dat = main_q;
    end else begin : g_noskid
      logic [DATA_W-1:0] main_q, main_d;
      logic              vld_q, vld_d;

      always_comb begin
        vld_d  = vld_q;
        main_d = main_q;
        if (flush) begin
          vld_d = 1'b0;
          if (ZERO_ON_FLUSH != 0) main_d = '0;
        end else if (xfer_in) begin
          vld_d  = 1'b1;
          main_d = up.data;
        end else if (xfer_out) begin
          vld_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          main_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          main_q <= main_d;
          vld_q  <= vld_d;
        end

      assign in_rdy  = !vld_q || dn.ready;
      assign out_vld = vld_q;
      assign out_dat = main_q;
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (out_vld && !dn.ready),
    .clr_i (stall_clr),
    .cnt_o (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: A = SKID=1/107-bit, B = SKID=1/CNT_W=4, C = SKID=0/ZERO_ON_FLUSH=0.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush_a = 1'b0, flush_b = 1'b0, flush_c = 1'b0;
  logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
  logic [15:0] cnt_a, cnt_c;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(EX_MEM_W)) a_up(), a_dn();
  pipe_stage_reg_if #(.DATA_W(8))        b_up(), b_dn();
  pipe_stage_reg_if #(.DATA_W(8))        c_up(), c_dn();

  pipe_stage_reg #(.DATA_W(EX_MEM_W), .SKID(1), .ZERO_ON_FLUSH(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .up(a_up), .dn(a_dn),
    .stall_clr(clr_a), .stall_cnt(cnt_a));

  pipe_stage_reg #(.DATA_W(8), .SKID(1), .ZERO_ON_FLUSH(1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .up(b_up), .dn(b_dn),
    .stall_clr(clr_b), .stall_cnt(cnt_b));

  pipe_stage_reg #(.DATA_W(8), .SKID(0), .ZERO_ON_FLUSH(0), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush_c), .up(c_up), .dn(c_dn),
    .stall_clr(clr_c), .stall_cnt(cnt_c));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
    b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;
    c_up.valid = 1'b0; c_up.data = '0; c_dn.ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_a_out_valid", 128'(a_dn.valid), 128'd0);
    chk("rst_a_out_data",  128'(a_dn.data),  128'd0);
    chk("rst_a_in_ready",  128'(a_up.ready), 128'd1);
    chk("rst_a_stall_cnt", 128'(cnt_a),      128'd0);
    chk("rst_c_in_ready",  128'(c_up.ready), 128'd1);
    rst_n = 1'b1;
    tick();

    // Stream 1..8 with out_ready=1: each word visible one edge after acceptance
    a_dn.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_up.valid = 1'b1;
      a_up.data  = 107'(i);
      tick();
      chk("stream_valid", 128'(a_dn.valid), 128'd1);
      chk("stream_data",  128'(a_dn.data),  128'(i));
      chk("stream_ready", 128'(a_up.ready), 128'd1);
    end
    a_up.valid = 1'b0;
    tick();
    chk("stream_drain_valid", 128'(a_dn.valid), 128'd0);

    // Backpressure A/B/C with 3 stalled cycles
    a_up.valid = 1'b1; a_up.data = 107'hA;
    tick();
    chk("bp_a_data", 128'(a_dn.data), 128'hA);
    a_dn.ready = 1'b0; a_up.data = 107'hB;
    tick();
    chk("bp_full_in_ready", 128'(a_up.ready), 128'd0);
    chk("bp_hold_a",        128'(a_dn.data),  128'hA);
    a_up.data = 107'hC;
    tick(); tick();
    chk("bp_still_full",  128'(a_up.ready), 128'd0);
    chk("bp_still_a",     128'(a_dn.data),  128'hA);
    chk("bp_stall_cnt_3", 128'(cnt_a),      128'd3);
    a_dn.ready = 1'b1;
    tick();
    chk("bp_b_data",        128'(a_dn.data),  128'hB);
    chk("bp_resume_ready",  128'(a_up.ready), 128'd1);
    chk("bp_stall_cnt_hold",128'(cnt_a),      128'd3);
    tick();
    chk("bp_c_data",  128'(a_dn.data),  128'hC);
    chk("bp_c_valid", 128'(a_dn.valid), 128'd1);
    a_up.valid = 1'b0;
    tick();
    chk("bp_drain_valid", 128'(a_dn.valid), 128'd0);

    // Flush while FULL with a word offered
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 107'h11;
    tick();
    a_up.data = 107'h22;
    tick();
    chk("fl_full_in_ready", 128'(a_up.ready), 128'd0);
    a_up.data = 107'h33; flush_a = 1'b1;
    tick();
    chk("fl_out_valid", 128'(a_dn.valid), 128'd0);
    chk("fl_out_data",  128'(a_dn.data),  128'd0);
    chk("fl_in_ready",  128'(a_up.ready), 128'd1);
    flush_a = 1'b0; a_up.valid = 1'b0; a_dn.ready = 1'b1;
    tick();
    chk("fl_no_ghost_valid", 128'(a_dn.valid), 128'd0);
    chk("fl_cnt_kept",       128'(cnt_a),      128'd5);

    // Asynchronous reset while FULL
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 107'h44;
    tick();
    a_up.data = 107'h55;
    tick();
    chk("ar_full_in_ready", 128'(a_up.ready), 128'd0);
    a_up.valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 128'(a_dn.valid), 128'd0);
    chk("ar_out_data",  128'(a_dn.data),  128'd0);
    chk("ar_in_ready",  128'(a_up.ready), 128'd1);
    chk("ar_stall_cnt", 128'(cnt_a),      128'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_post_valid", 128'(a_dn.valid), 128'd0);

    // Stall counter saturation on the 4-bit instance
    b_up.valid = 1'b1; b_up.data = 8'h5;
    tick();
    b_up.valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt_15", 128'(cnt_b),      128'd15);
    chk("sat_data",   128'(b_dn.data),  128'h5);
    clr_b = 1'b1;
    tick();
    chk("sat_clr_wins", 128'(cnt_b), 128'd0);
    clr_b = 1'b0;
    tick();
    chk("sat_after_clr", 128'(cnt_b), 128'd1);

    // SKID=0: combinational in_ready, flush keeps data
    c_up.valid = 1'b1; c_up.data = 8'h3C;
    tick();
    c_up.valid = 1'b0;
    chk("c_valid", 128'(c_dn.valid), 128'd1);
    chk("c_data",  128'(c_dn.data),  128'h3C);
    chk("c_rdy_blocked", 128'(c_up.ready), 128'd0);
    c_dn.ready = 1'b1;
    #1 chk("c_rdy_follows_1", 128'(c_up.ready), 128'd1);
    c_dn.ready = 1'b0;
    #1 chk("c_rdy_follows_0", 128'(c_up.ready), 128'd0);
    flush_c = 1'b1; c_up.valid = 1'b1; c_up.data = 8'h99;
    tick();
    chk("c_fl_valid",    128'(c_dn.valid), 128'd0);
    chk("c_fl_data_kept",128'(c_dn.data),  128'h3C);
    chk("c_fl_in_ready", 128'(c_up.ready), 128'd1);
    flush_c = 1'b0; c_up.valid = 1'b0;
    tick();
    chk("c_no_ghost", 128'(c_dn.valid), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
